// File: rtl/clock_switch_pkg.sv
// clock_switch_pkg: shared FSM state encoding and default timing constants
// for the N-way glitch-free clock switch.
`default_nettype none

package clock_switch_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_DISABLE = 2'd2,
    ST_ENABLE  = 2'd3
  } sw_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 256;

endpackage

`default_nettype wire

// File: rtl/clk_gate_chan.sv
// clk_gate_chan: one source channel - request synchroniser into the source
// domain, negedge gate flop, clock AND gate, and acknowledge back to clkA.
`default_nettype none

module clk_gate_chan
  import clock_switch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clkA,
  input  logic rst_n,
  input  logic clk_in,
  input  logic en_req,
  output logic en_ack,
  output logic clk_gated
);

  logic [SYNC_STAGES-1:0] fwd_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   gate_en;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) fwd_sync <= '0;
    else        fwd_sync <= {fwd_sync[SYNC_STAGES-2:0], en_req};
  end

  // Updating on the falling edge keeps the gate change inside the low phase,
  // so the AND below can never truncate a high pulse.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) gate_en <= 1'b0;
    else        gate_en <= fwd_sync[SYNC_STAGES-1];
  end

  assign clk_gated = clk_in & gate_en;

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], gate_en};
  end

  assign en_ack = ack_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/clock_switch_nway.sv
// clock_switch_nway: glitch-free N-way clock mux with clkA-domain switch
// handshake, startup default channel, status outputs and dead-source timeout.
`default_nettype none

module clock_switch_nway
  import clock_switch_pkg::*;
#(
  parameter int N_CLK       = 4,
  parameter int SEL_W       = $clog2(N_CLK),
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_SEL     = 0,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clkA,
  input  logic             rst_n,
  input  logic [N_CLK-1:0] clk_in,
  input  logic             sel_req,
  input  logic [SEL_W-1:0] sel_idx,
  output logic             sel_busy,
  output logic [SEL_W-1:0] cur_sel,
  output logic             sw_done,
  output logic             sw_err,
  output logic             clk_out
);

  localparam int               CNT_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [N_CLK-1:0] RST_ONEHOT = N_CLK'(1) << RST_SEL;

  sw_state_e        state, state_nxt;
  logic [N_CLK-1:0] en_req, en_req_nxt, en_ack, clk_gated;
  logic [N_CLK-1:0] cur_onehot, tgt_onehot;
  logic [SEL_W-1:0] target, target_nxt, cur_sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             boot, boot_nxt, sw_err_nxt, sw_done_nxt;
  logic             ack_cur, ack_tgt, idx_valid, timeout;

  for (genvar i = 0; i < N_CLK; i++) begin : g_chan
    clk_gate_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clkA      (clkA),
      .rst_n     (rst_n),
      .clk_in    (clk_in[i]),
      .en_req    (en_req[i]),
      .en_ack    (en_ack[i]),
      .clk_gated (clk_gated[i])
    );
  end

  assign clk_out = |clk_gated;

  always_comb begin
    cur_onehot = '0;
    tgt_onehot = '0;
    for (int i = 0; i < N_CLK; i++) begin
      cur_onehot[i] = (cur_sel == SEL_W'(i));
      tgt_onehot[i] = (target == SEL_W'(i));
    end
  end

  assign ack_cur   = |(en_ack & cur_onehot);
  assign ack_tgt   = |(en_ack & tgt_onehot);
  assign idx_valid = int'(sel_idx) < N_CLK;
  assign timeout   = (cnt >= CNT_W'(TIMEOUT_CYC - 1));
  assign sel_busy  = (state != ST_IDLE);

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) state <= ST_STARTUP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    en_req_nxt  = en_req;
    target_nxt  = target;
    cur_sel_nxt = cur_sel;
    sw_err_nxt  = sw_err;
    sw_done_nxt = 1'b0;
    boot_nxt    = boot;
    cnt_nxt     = (cnt < CNT_W'(TIMEOUT_CYC)) ? cnt + 1'b1 : cnt;
    unique case (state)
      ST_STARTUP: begin
        target_nxt = SEL_W'(RST_SEL);
        en_req_nxt = RST_ONEHOT;
        boot_nxt   = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = ST_ENABLE;
      end
      ST_IDLE: begin
        cnt_nxt = '0;
        if (sel_req && idx_valid) begin
          if (sel_idx == cur_sel) begin
            sw_done_nxt = 1'b1;
          end else begin
            target_nxt = sel_idx;
            sw_err_nxt = 1'b0;
            en_req_nxt = en_req & ~cur_onehot;
            state_nxt  = ST_DISABLE;
          end
        end
      end
      ST_DISABLE: begin
        // A dead old source never acknowledges; move on after the timeout.
        if (!ack_cur || timeout) begin
          if (ack_cur) sw_err_nxt = 1'b1;
          en_req_nxt = en_req | tgt_onehot;
          cnt_nxt    = '0;
          state_nxt  = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (ack_tgt) begin
          cur_sel_nxt = target;
          sw_done_nxt = !boot;
          boot_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end else if (timeout) begin
          // Request stays asserted so the gate opens cleanly if the source starts.
          sw_err_nxt  = 1'b1;
          cur_sel_nxt = target;
          boot_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      en_req  <= '0;
      target  <= SEL_W'(RST_SEL);
      cur_sel <= SEL_W'(RST_SEL);
      cnt     <= '0;
      boot    <= 1'b1;
      sw_err  <= 1'b0;
      sw_done <= 1'b0;
    end else begin
      en_req  <= en_req_nxt;
      target  <= target_nxt;
      cur_sel <= cur_sel_nxt;
      cnt     <= cnt_nxt;
      boot    <= boot_nxt;
      sw_err  <= sw_err_nxt;
      sw_done <= sw_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_switch_nway.sv
// tb_clock_switch_nway: scoreboard bench for the N-way clock switch with
// a clk_out phase monitor for runt-pulse detection.
`default_nettype none
`timescale 1ns/1ps

module tb_clock_switch_nway;

  localparam int N_CLK       = 4;
  localparam int SEL_W       = 3;
  localparam int SYNC_STAGES = 2;
  localparam int RST_SEL     = 2;
  localparam int TIMEOUT_CYC = 64;

  logic             clkA    = 1'b0;
  logic             rst_n   = 1'b0;
  logic             sel_req = 1'b0;
  logic [SEL_W-1:0] sel_idx = '0;
  logic [N_CLK-1:0] clk_in  = '0;
  logic [N_CLK-1:0] run     = '1;
  logic             sel_busy, sw_done, sw_err, clk_out;
  logic [SEL_W-1:0] cur_sel;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             err;
    logic [3:0]       ndone;
    logic             busy;
  } exp_t;
  exp_t sb_q[$];

  clock_switch_nway #(
    .N_CLK(N_CLK), .SEL_W(SEL_W), .SYNC_STAGES(SYNC_STAGES),
    .RST_SEL(RST_SEL), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clkA(clkA), .rst_n(rst_n), .clk_in(clk_in), .sel_req(sel_req),
    .sel_idx(sel_idx), .sel_busy(sel_busy), .cur_sel(cur_sel),
    .sw_done(sw_done), .sw_err(sw_err), .clk_out(clk_out)
  );

  // 100 MHz control clock; sources 800/500/1000/333 MHz, stoppable (held low).
  always #5 clkA = ~clkA;
  always begin #0.625; clk_in[0] = run[0] ? ~clk_in[0] : 1'b0; end
  always begin #1.0;   clk_in[1] = run[1] ? ~clk_in[1] : 1'b0; end
  always begin #0.5;   clk_in[2] = run[2] ? ~clk_in[2] : 1'b0; end
  always begin #1.5;   clk_in[3] = run[3] ? ~clk_in[3] : 1'b0; end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Phase monitor: shortest phase and longest low phase since last clear.
  realtime last_edge = 0.0;
  realtime ph;
  real     min_phase, max_low;
  bit      mon_first;

  always @(clk_out) begin
    if (!mon_first) begin
      ph = $realtime - last_edge;
      if (ph < min_phase) min_phase = ph;
      if (clk_out && ph > max_low) max_low = ph;
    end
    mon_first = 1'b0;
    last_edge = $realtime;
  end

  task automatic clear_mon();
    min_phase = 1.0e9;
    max_low   = 0.0;
    mon_first = 1'b1;
  endtask

  logic [1:0] mon_ch = 2'd2;
  logic       mon_clk;
  assign mon_clk = clk_in[mon_ch];

  task automatic follow(input logic [1:0] ch, input string tag);
    mon_ch = ch;
    #0.01;
    repeat (3) begin
      @(posedge mon_clk); #0.2;
      check_eq({tag, "_hi"}, 32'(clk_out), 32'd1);
      @(negedge mon_clk); #0.2;
      check_eq({tag, "_lo"}, 32'(clk_out), 32'd0);
    end
  endtask

  task automatic expect_low(input string tag);
    int highs = 0;
    repeat (16) begin
      #0.37;
      if (clk_out) highs++;
    end
    check_eq(tag, highs, 0);
  endtask

  function automatic exp_t mk(input int sel, input bit err, input int nd, input bit busy);
    exp_t e;
    e.sel   = SEL_W'(sel);
    e.err   = err;
    e.ndone = 4'(nd);
    e.busy  = busy;
    return e;
  endfunction

  task automatic request(input int idx, input exp_t e);
    sb_q.push_back(e);
    @(negedge clkA);
    sel_idx = SEL_W'(idx);
    sel_req = 1'b1;
  endtask

  // Completes one operation: optional mid-switch request, bounded wait for
  // idle, then scores cur_sel/sw_err/done-count/busy against the queue head.
  task automatic run_op(input string tag, input bit do_extra,
                        input logic [SEL_W-1:0] extra_idx, input int max_cyc);
    int   dn = 0;
    int   k  = 0;
    bit   bs = 1'b0;
    exp_t e;
    @(negedge clkA);
    sel_req = 1'b0;
    if (sw_done)  dn++;
    if (sel_busy) bs = 1'b1;
    while (sel_busy && k < max_cyc) begin
      @(negedge clkA);
      k++;
      sel_req = do_extra && (k == 2);
      if (do_extra && k == 2) sel_idx = extra_idx;
      if (sw_done) dn++;
    end
    sel_req = 1'b0;
    check_eq({tag, "_bound"}, 32'(k < max_cyc), 32'd1);
    repeat (3) begin
      @(negedge clkA);
      if (sw_done) dn++;
    end
    check_eq({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_cur_sel"}, 32'(cur_sel), 32'(e.sel));
      check_eq({tag, "_sw_err"},  32'(sw_err),  32'(e.err));
      check_eq({tag, "_ndone"},   dn,           32'(e.ndone));
      check_eq({tag, "_busy"},    32'(bs),      32'(e.busy));
    end
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge clkA);
    expect_low("rst_clk_out");
    check_eq("rst_busy",    32'(sel_busy), 32'd1);
    check_eq("rst_cur_sel", 32'(cur_sel),  32'(RST_SEL));
    check_eq("rst_done",    32'(sw_done),  32'd0);
    check_eq("rst_err",     32'(sw_err),   32'd0);

    sb_q.push_back(mk(RST_SEL, 0, 0, 1));
    rst_n = 1'b1;
    run_op("boot", 1'b0, '0, 200);
    follow(2'd2, "boot_follow");

    clear_mon();
    request(1, mk(1, 0, 1, 1));
    run_op("sw21", 1'b0, '0, 200);
    check_eq("sw21_runt", 32'(min_phase >= 0.49), 32'd1);
    check_eq("sw21_gap",  32'(max_low >= 10.0),   32'd1);
    follow(2'd1, "sw21_follow");

    request(0, mk(0, 0, 1, 1));
    run_op("sw10", 1'b0, '0, 200);

    run[0] = 1'b0;
    repeat (2) @(negedge clkA);
    clear_mon();
    request(3, mk(3, 1, 1, 1));
    run_op("dead_old", 1'b0, '0, 400);
    check_eq("dead_old_runt", 32'(min_phase >= 1.49), 32'd1);
    follow(2'd3, "dead_old_follow");

    run[1] = 1'b0;
    repeat (2) @(negedge clkA);
    request(1, mk(1, 1, 0, 1));
    run_op("dead_new", 1'b0, '0, 400);
    expect_low("dead_new_low");
    clear_mon();
    run[1] = 1'b1;
    repeat (10) @(negedge clkA);
    check_eq("dead_new_runt",   32'(min_phase >= 0.99), 32'd1);
    check_eq("dead_new_sticky", 32'(sw_err), 32'd1);
    follow(2'd1, "dead_new_follow");

    request(2, mk(2, 0, 1, 1));
    run_op("busy_req", 1'b1, SEL_W'(3), 200);

    request(5, mk(2, 0, 0, 0));
    run_op("bad_idx", 1'b0, '0, 200);

    clear_mon();
    request(2, mk(2, 0, 1, 0));
    run_op("same_sel", 1'b0, '0, 200);
    check_eq("same_sel_runt", 32'(min_phase >= 0.49), 32'd1);
    follow(2'd2, "same_sel_follow");

    @(negedge clkA);
    sel_idx = SEL_W'(3);
    sel_req = 1'b1;
    @(negedge clkA);
    sel_req = 1'b0;
    check_eq("rst_mid_busy", 32'(sel_busy), 32'd1);
    rst_n = 1'b0;
    #0.1;
    check_eq("rst_mid_clk", 32'(clk_out), 32'd0);
    expect_low("rst_mid_low");
    run[0] = 1'b1;
    repeat (3) @(negedge clkA);
    check_eq("rst_mid_cur_sel", 32'(cur_sel),  32'(RST_SEL));
    check_eq("rst_mid_busy2",   32'(sel_busy), 32'd1);
    check_eq("rst_mid_err",     32'(sw_err),   32'd0);
    sb_q.push_back(mk(RST_SEL, 0, 0, 1));
    rst_n = 1'b1;
    run_op("reboot", 1'b0, '0, 200);
    follow(2'd2, "reboot_follow");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
